// File: rtl/tmds_decoder.sv
// TMDS channel decoder: finds 10-bit word alignment by hunting for runs of
// control tokens across the ten possible bit-slip offsets, then decodes
// aligned symbols into pixel bytes or control bits.
module tmds_decoder #(
  parameter int LOCK_TOKENS    = 16,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
) (
  input  logic       i_hdmi_clk,
  input  logic       i_reset_n,
  input  logic [9:0] i_tmds,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_display_enable,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  // One idle counter serves both timeouts, so it is sized for the larger one.
  localparam int IDLE_MAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int RUN_W    = $clog2(LOCK_TOKENS + 1);
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

  localparam logic [RUN_W-1:0]  RUN_LOCK    = RUN_W'(LOCK_TOKENS);
  localparam logic [IDLE_W-1:0] IDLE_SEARCH = IDLE_W'(SEARCH_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LOSS   = IDLE_W'(LOSS_TIMEOUT);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  logic              en_q;
  logic [9:0]        prev_q;
  state_e            state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d, run_inc;
  logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
  logic [3:0]        offset_q, offset_d, offset_nxt;
  logic [7:0]        data_q, data_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              de_q, de_d;
  logic              locked_q, locked_d;

  logic [19:0]       hist;
  logic [9:0]        sym;
  logic              is_tok;
  logic [1:0]        tok_ctrl;
  logic [7:0]        dmask;
  logic [7:0]        dec;

  // Reset release is retimed by one flop; all other state holds until it is set.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) en_q <= 1'b0;
    else            en_q <= 1'b1;
  end

  // Previous word, so a symbol straddling two words can be reassembled.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n)  prev_q <= '0;
    else if (en_q)   prev_q <= i_tmds;
  end

  // Barrel-select the aligned symbol out of the 20-bit history (bit 0 earliest).
  always_comb begin
    hist = {i_tmds, prev_q};
    sym  = 10'(hist >> offset_q);
  end

  // Control token recognition.
  always_comb begin
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (sym)
      10'h354: tok_ctrl = 2'b00;
      10'h0AB: tok_ctrl = 2'b01;
      10'h154: tok_ctrl = 2'b10;
      10'h2AB: tok_ctrl = 2'b11;
      default: is_tok   = 1'b0;
    endcase
  end

  // Data symbol decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    dmask  = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = '0;
    dec[0] = dmask[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym[8] ? (dmask[i] ^ dmask[i-1]) : ~(dmask[i] ^ dmask[i-1]);
    end
  end

  // Saturating counter increments and the wrapping bit-slip step.
  always_comb begin
    run_inc    = (run_q  == '1) ? run_q  : run_q  + 1'b1;
    idle_inc   = (idle_q == '1) ? idle_q : idle_q + 1'b1;
    offset_nxt = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  end

  // Alignment FSM next state: token runs lock, token droughts slip or unlock.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    idle_d   = idle_q;
    offset_d = offset_q;
    case (state_q)
      ST_SEARCH: begin
        if (is_tok) begin
          idle_d = '0;
          if (run_inc >= RUN_LOCK) begin
            state_d = ST_LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end else begin
          run_d = '0;
          if (idle_inc >= IDLE_SEARCH) begin
            offset_d = offset_nxt;
            idle_d   = '0;
          end else begin
            idle_d = idle_inc;
          end
        end
      end
      ST_LOCKED: begin
        if (is_tok) begin
          idle_d = '0;
        end else if (idle_inc >= IDLE_LOSS) begin
          state_d  = ST_SEARCH;
          offset_d = offset_nxt;
          run_d    = '0;
          idle_d   = '0;
        end else begin
          idle_d = idle_inc;
        end
      end
    endcase
  end

  // Output next state follows the state being entered, so o_locked and the
  // first/last locked-mode outputs change on the same edge.
  always_comb begin
    data_d   = '0;
    ctrl_d   = '0;
    de_d     = 1'b0;
    locked_d = (state_d == ST_LOCKED);
    if (state_d == ST_LOCKED) begin
      if (is_tok) begin
        ctrl_d = tok_ctrl;
      end else begin
        de_d   = 1'b1;
        data_d = dec;
        ctrl_d = ctrl_q;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_SEARCH;
      run_q    <= '0;
      idle_q   <= '0;
      offset_q <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      de_q     <= 1'b0;
      locked_q <= 1'b0;
    end else if (en_q) begin
      state_q  <= state_d;
      run_q    <= run_d;
      idle_q   <= idle_d;
      offset_q <= offset_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      de_q     <= de_d;
      locked_q <= locked_d;
    end
  end

  assign o_data           = data_q;
  assign o_ctrl           = ctrl_q;
  assign o_display_enable = de_q;
  assign o_locked         = locked_q;
  assign o_offset         = offset_q;

endmodule
